// File: rtl/mdu_32bit_if.sv
// Handshake and HI/LO bus between the execute stage and the multiply/divide unit.
interface mdu_32bit_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, mthi, mtlo, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_32bit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit owning HI/LO, with start/busy/done handshake
// and direct MTHI/MTLO writes. Operands are reduced to magnitudes, sign is fixed up at the end.
module mdu_32bit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input logic        clk,
    input logic        reset,
    mdu_32bit_if.slave bus
);
    localparam int CW = $clog2(ITER);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt;
    logic                 busy, accept, mt_ok, sgn, last_step;

    logic                 div_p0, neg_q_p0, neg_r_p0;
    logic [WIDTH-1:0]     a_raw_p0, opnd_p0, sh_p0, rem_p0;
    logic [2*WIDTH-1:0]   acc_p0;

    logic [WIDTH:0]       mul_sum, rem_sh, rem_dif;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     fix_hi, fix_lo;

    logic                 vld_p1;
    logic [WIDTH-1:0]     hi_p1, lo_p1;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
        return (s && v[WIDTH-1]) ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    assign sgn       = ~bus.op[0];
    assign last_step = (cnt == CW'(ITER - 1));
    assign accept    = bus.start && !busy;
    assign mt_ok     = !bus.start && !busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last_step) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // busy stays high through the write-back cycle after FIX
    always_comb begin
        busy = (state != IDLE) || vld_p1;
    end
    assign bus.busy = busy;

    always_comb begin
        mul_sum = {1'b0, acc_p0[2*WIDTH-1:WIDTH]}
                + (sh_p0[0] ? {1'b0, opnd_p0} : {(WIDTH+1){1'b0}});
        rem_sh  = {rem_p0, sh_p0[WIDTH-1]};
        rem_dif = rem_sh - {1'b0, opnd_p0};
    end

    always_comb begin
        prod   = neg_2w(acc_p0, neg_q_p0);
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
        if (div_p0) begin
            if (opnd_p0 == '0) begin
                fix_hi = a_raw_p0;
                fix_lo = '1;
            end else begin
                fix_hi = neg_w(rem_p0, neg_r_p0);
                fix_lo = neg_w(sh_p0, neg_q_p0);
            end
        end
    end

    // stage p0: operand latch and one shift-add / shift-subtract step per RUN cycle
    always_ff @(posedge clk) begin
        if (accept) begin
            div_p0   <= bus.op[1];
            neg_q_p0 <= sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_r_p0 <= sgn & bus.a[WIDTH-1];
            a_raw_p0 <= bus.a;
            opnd_p0  <= bus.op[1] ? mag(bus.b, sgn) : mag(bus.a, sgn);
            sh_p0    <= bus.op[1] ? mag(bus.a, sgn) : mag(bus.b, sgn);
            acc_p0   <= '0;
            rem_p0   <= '0;
        end else if (state == RUN) begin
            if (!div_p0) begin
                acc_p0 <= {mul_sum, acc_p0[WIDTH-1:1]};
                sh_p0  <= sh_p0 >> 1;
            end else begin
                rem_p0 <= rem_dif[WIDTH] ? rem_sh[WIDTH-1:0] : rem_dif[WIDTH-1:0];
                sh_p0  <= {sh_p0[WIDTH-2:0], ~rem_dif[WIDTH]};
            end
        end
    end

    // stage p1: sign-fixed result waiting for write-back
    always_ff @(posedge clk) begin
        if (state == FIX) begin
            hi_p1 <= fix_hi;
            lo_p1 <= fix_lo;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            vld_p1 <= 1'b0;
            bus.done <= 1'b0;
            bus.hi <= '0;
            bus.lo <= '0;
        end else begin
            if (accept)             cnt <= '0;
            else if (state == RUN)  cnt <= cnt + CW'(1);
            vld_p1   <= (state == FIX);
            bus.done <= vld_p1;
            if (vld_p1) begin
                bus.hi <= hi_p1;
                bus.lo <= lo_p1;
            end else if (mt_ok) begin
                if (bus.mthi) bus.hi <= bus.wdata;
                if (bus.mtlo) bus.lo <= bus.wdata;
            end
        end
    end
endmodule

// File: tb/tb_mdu_32bit.sv
// Self-checking bench for mdu_32bit: directed cases plus random ops against an arithmetic model.
module tb_mdu_32bit;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mdu_32bit_if bus_if ();

    mdu_32bit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // {hi, lo} computed directly from the arithmetic definition of each op
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] ua, ub, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            2'b00:   r = 64'(sa * sb);
            2'b01:   r = ua * ub;
            2'b10:   r = (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
            default: r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
        endcase
        return r;
    endfunction

    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo);
        int n;
        bus_if.start = 1'b1;
        bus_if.op    = op;
        bus_if.a     = a;
        bus_if.b     = b;
        tick;
        bus_if.start = 1'b0;
        chk({tag, ".busy_e0"}, 32'(bus_if.busy), 32'd1);
        n = 0;
        while (!bus_if.done && n < 100) begin
            tick;
            n++;
        end
        chk({tag, ".latency"}, 32'(n), 32'd34);
        chk({tag, ".hi"}, bus_if.hi, exp_hi);
        chk({tag, ".lo"}, bus_if.lo, exp_lo);
        chk({tag, ".busy_done"}, 32'(bus_if.busy), 32'd0);
        tick;
        chk({tag, ".done_pulse"}, 32'(bus_if.done), 32'd0);
    endtask

    function automatic logic [31:0] pick_val(input bit allow_zero);
        logic [31:0] specials [6];
        int          k;
        specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h3};
        k = $urandom_range(0, 9);
        if (k < 6 && (allow_zero || k != 0)) return specials[k];
        return $urandom;
    endfunction

    initial begin
        logic [63:0] r;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        int          n;

        reset = 1'b1;
        bus_if.start = 1'b0;
        bus_if.op    = 2'b00;
        bus_if.a     = '0;
        bus_if.b     = '0;
        bus_if.mthi  = 1'b0;
        bus_if.mtlo  = 1'b0;
        bus_if.wdata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        tick;
        chk("rst.hi", bus_if.hi, 32'h0);
        chk("rst.lo", bus_if.lo, 32'h0);
        chk("rst.busy", 32'(bus_if.busy), 32'd0);
        chk("rst.done", 32'(bus_if.done), 32'd0);

        do_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        do_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        do_op("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
        do_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op("divu_7_2", 2'b11, 32'd7, 32'd2, 32'd1, 32'd3);
        do_op("divu_zero", 2'b11, 32'h64, 32'd0, 32'h64, 32'hFFFF_FFFF);
        do_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        do_op("div_zero", 2'b10, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 32'hFFFF_FFFF);

        // start and MTHI arriving while busy must both be dropped
        bus_if.start = 1'b1;
        bus_if.op    = 2'b01;
        bus_if.a     = 32'd3;
        bus_if.b     = 32'd4;
        tick;
        bus_if.start = 1'b0;
        repeat (4) tick;
        bus_if.start = 1'b1;
        bus_if.op    = 2'b10;
        bus_if.a     = 32'd100;
        bus_if.b     = 32'd7;
        tick;
        bus_if.start = 1'b0;
        bus_if.mthi  = 1'b1;
        bus_if.wdata = 32'hDEAD_BEEF;
        tick;
        bus_if.mthi  = 1'b0;
        n = 6;
        while (!bus_if.done && n < 100) begin
            tick;
            n++;
        end
        chk("busy_ign.latency", 32'(n), 32'd34);
        chk("busy_ign.hi", bus_if.hi, 32'h0);
        chk("busy_ign.lo", bus_if.lo, 32'h0000_000C);
        tick;
        chk("busy_ign.no_restart", 32'(bus_if.busy), 32'd0);
        bus_if.mtlo  = 1'b1;
        bus_if.wdata = 32'h1234_5678;
        tick;
        bus_if.mtlo  = 1'b0;
        chk("mtlo.lo", bus_if.lo, 32'h1234_5678);
        chk("mtlo.hi", bus_if.hi, 32'h0);
        chk("mtlo.done", 32'(bus_if.done), 32'd0);

        bus_if.mthi  = 1'b1;
        bus_if.mtlo  = 1'b1;
        bus_if.wdata = 32'hCAFE_F00D;
        tick;
        chk("mt_both.hi", bus_if.hi, 32'hCAFE_F00D);
        chk("mt_both.lo", bus_if.lo, 32'hCAFE_F00D);
        // start in the same cycle as MTHI/MTLO takes priority
        bus_if.wdata = 32'h0BAD_0BAD;
        bus_if.start = 1'b1;
        bus_if.op    = 2'b11;
        bus_if.a     = 32'd9;
        bus_if.b     = 32'd4;
        tick;
        bus_if.start = 1'b0;
        bus_if.mthi  = 1'b0;
        bus_if.mtlo  = 1'b0;
        chk("mt_vs_start.hi", bus_if.hi, 32'hCAFE_F00D);
        chk("mt_vs_start.busy", 32'(bus_if.busy), 32'd1);
        n = 0;
        while (!bus_if.done && n < 100) begin
            tick;
            n++;
        end
        chk("mt_vs_start.lo", bus_if.lo, 32'd2);
        tick;

        // asynchronous reset mid-divide discards everything
        bus_if.mthi  = 1'b1;
        bus_if.wdata = 32'hAAAA_AAAA;
        tick;
        bus_if.mthi  = 1'b0;
        bus_if.mtlo  = 1'b1;
        bus_if.wdata = 32'h5555_5555;
        tick;
        bus_if.mtlo  = 1'b0;
        chk("pre_abort.hi", bus_if.hi, 32'hAAAA_AAAA);
        chk("pre_abort.lo", bus_if.lo, 32'h5555_5555);
        bus_if.start = 1'b1;
        bus_if.op    = 2'b11;
        bus_if.a     = 32'd100;
        bus_if.b     = 32'd3;
        tick;
        bus_if.start = 1'b0;
        repeat (9) tick;
        #2 reset = 1'b1;
        #1;
        chk("abort.busy", 32'(bus_if.busy), 32'd0);
        chk("abort.hi", bus_if.hi, 32'h0);
        chk("abort.lo", bus_if.lo, 32'h0);
        chk("abort.done", 32'(bus_if.done), 32'd0);
        #2 reset = 1'b0;
        tick;
        chk("post_abort.busy", 32'(bus_if.busy), 32'd0);
        do_op("divu_100_3", 2'b11, 32'd100, 32'd3, 32'd1, 32'h21);

        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = pick_val(1'b1);
            rb  = ($urandom_range(0, 7) == 0) ? 32'h0 : pick_val(1'b0);
            r   = ref_result(rop, ra, rb);
            do_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, r[63:32], r[31:0]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
